// File: rtl/alu_ram_seq.sv
// Command sequencer for the ALU + RAM datapath: reads two operands from the
// single-port RAM, drives the ALU, captures result/ZF and optionally writes back.
module alu_ram_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_d,
  input  logic              cmd_wb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ZF,
  output logic [15:0]       op_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zf
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, DONE} state_t;

  state_t state, next_state;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] b_q;
  logic [ADDR_W-1:0] d_q;
  logic              wb_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [15:0]       op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RD_A;
      RD_A:    next_state = RD_B;
      RD_B:    next_state = EXEC;
      EXEC:    next_state = wb_q ? WB : DONE;
      WB:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand B comes straight from the RAM in EXEC and is held afterwards.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    ram_we = (state == WB);
    alu_b  = (state == EXEC) ? ram_rdata : alu_b_q;
  end

  assign ram_wdata = result;
  assign op_count  = op_count_q;

  // ram_addr is loaded one edge ahead so it is a clean register in each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      b_q        <= '0;
      d_q        <= '0;
      wb_q       <= 1'b0;
      ram_addr   <= '0;
      alu_a      <= '0;
      alu_op     <= '0;
      alu_b_q    <= '0;
      result     <= '0;
      ZF         <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= cmd_op;
            b_q      <= cmd_b;
            d_q      <= cmd_d;
            wb_q     <= cmd_wb;
            ram_addr <= cmd_a;
          end
        end
        RD_A: ram_addr <= b_q;
        RD_B: begin
          alu_a  <= ram_rdata;
          alu_op <= op_q;
        end
        EXEC: begin
          result  <= alu_y;
          ZF      <= alu_zf;
          alu_b_q <= ram_rdata;
          if (wb_q) ram_addr <= d_q;
        end
        DONE:    op_count_q <= op_count_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ram_seq.sv
// Randomized bench for alu_ram_seq: a transaction-level timeline model predicts
// every output cycle by cycle, plus directed literal checks from the test plan.
module tb_alu_ram_seq;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [OP_W-1:0]   cmd_op = '0;
  logic [ADDR_W-1:0] cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic              cmd_wb = 1'b0;
  logic              busy, done, ZF, ram_we, alu_zf;
  logic [DATA_W-1:0] result, ram_wdata, ram_rdata, alu_a, alu_b, alu_y;
  logic [15:0]       op_count;
  logic [ADDR_W-1:0] ram_addr;
  logic [OP_W-1:0]   alu_op;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  alu_ram_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_wb(cmd_wb),
    .busy(busy), .done(done), .result(result), .ZF(ZF), .op_count(op_count),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_zf(alu_zf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] aluFn(input logic [OP_W-1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_y  = aluFn(alu_op, alu_a, alu_b);
  assign alu_zf = (alu_y == '0);

  // Synchronous read-first RAM with a bench-side preload port.
  logic [DATA_W-1:0] ram [0:31];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)       ram[pl_addr]  <= pl_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Timeline model: m_k counts edges since the accepting edge.
  logic [DATA_W-1:0] m_mem [0:31];
  bit                m_active = 0;
  int                m_k = 0;
  logic [OP_W-1:0]   m_op = '0;
  logic [ADDR_W-1:0] m_d = '0;
  bit                m_wb = 0;
  logic [DATA_W-1:0] m_opa = '0, m_opb = '0, m_y = '0, m_result = '0;
  bit                m_zf = 0;
  logic [15:0]       m_count = '0;
  bit                was_idle;
  bit                cnt_sync = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_k      = 0;
      m_result = '0;
      m_zf     = 0;
      m_count  = '0;
    end else begin
      was_idle = !m_active;
      if (pl_en) m_mem[pl_addr] = pl_data;
      if (cnt_sync) m_count = 16'hFFFE;
      if (m_active) begin
        m_k++;
        if (m_k == 3) begin
          m_result = m_y;
          m_zf     = (m_y == '0);
        end
        if (m_k == 4 && m_wb) m_mem[m_d] = m_y;
        if (m_k == (m_wb ? 5 : 4)) begin
          m_active = 0;
          m_count  = m_count + 16'd1;
        end
      end
      if (was_idle && start) begin
        m_op     = cmd_op;
        m_d      = cmd_d;
        m_wb     = cmd_wb;
        m_opa    = m_mem[cmd_a];
        m_opb    = m_mem[cmd_b];
        m_y      = aluFn(cmd_op, m_opa, m_opb);
        m_active = 1;
        m_k      = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    checkOutput("busy", busy, m_active);
    checkOutput("done", done, m_active && (m_k == (m_wb ? 4 : 3)));
    checkOutput("ram_we", ram_we, m_active && m_wb && (m_k == 3));
    checkOutput("result", result, m_result);
    checkOutput("ZF", ZF, m_zf);
    checkOutput("op_count", op_count, m_count);
    if (m_active && m_k == 2) begin
      checkOutput("alu_a", alu_a, m_opa);
      checkOutput("alu_b", alu_b, m_opb);
      checkOutput("alu_op", alu_op, m_op);
    end
    if (m_active && m_wb && m_k == 3) begin
      checkOutput("ram_addr_wb", ram_addr, m_d);
      checkOutput("ram_wdata_wb", ram_wdata, m_y);
    end
    if (!rst_n) begin
      checkOutput("rst_ram_addr", ram_addr, '0);
      checkOutput("rst_ram_wdata", ram_wdata, '0);
      checkOutput("rst_alu_a", alu_a, '0);
      checkOutput("rst_alu_b", alu_b, '0);
      checkOutput("rst_alu_op", alu_op, '0);
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    @(posedge clk); #2;
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #2;
    pl_en = 1'b0;
  endtask

  task automatic scrambleCmd();
    cmd_op = OP_W'($urandom);
    cmd_a  = ADDR_W'($urandom);
    cmd_b  = ADDR_W'($urandom);
    cmd_d  = ADDR_W'($urandom);
    cmd_wb = 1'($urandom);
  endtask

  // mode 0: quiet, 1: random start noise while busy, 2: one rogue start sampled at N+2.
  // lat is the number of edges from acceptance to the cycle where done is seen.
  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d,
                               input logic wb, input int mode, output int lat);
    int acc;
    @(posedge clk); #2;
    start = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d; cmd_wb = wb;
    @(posedge clk); #2;
    acc = cyc;
    start = 1'b0;
    scrambleCmd();
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat   = cyc - acc;
        start = 1'b0;
        break;
      end
      if (mode == 1) begin
        start = ($urandom_range(0, 2) == 0);
        scrambleCmd();
      end else if (mode == 2) begin
        if (i == 1) begin
          start = 1'b1; cmd_op = 4'd0; cmd_a = 5'd1; cmd_b = 5'd2; cmd_d = 5'd11; cmd_wb = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  task automatic abortAt(input int k, input logic [ADDR_W-1:0] d);
    logic [DATA_W-1:0] old_d;
    int                dc;
    old_d = ram[d];
    dc    = done_cnt;
    @(posedge clk); #2;
    start = 1'b1; cmd_op = 4'd0; cmd_a = 5'd1; cmd_b = 5'd2; cmd_d = d; cmd_wb = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (k) @(posedge clk);
    #2;
    if (k == 3) checkOutput("ram_we_before_abort", ram_we, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("ram_we_async_drop", ram_we, 0);
    checkOutput("busy_async_drop", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("abort_no_write", ram[d], old_d);
    checkOutput("abort_no_done", done_cnt - dc, 0);
    checkOutput("abort_op_count", op_count, 16'd0);
  endtask

  initial begin
    int lat;
    int dc;
    logic [DATA_W-1:0] old7;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_op_count", op_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) preload(ADDR_W'(i), $urandom);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 0, lat);
    checkOutput("add_done_offset", lat, 4);
    checkOutput("add_result", result, 32'd12);
    checkOutput("add_zf", ZF, 0);
    checkOutput("add_ram3", ram[3], 32'd12);
    checkOutput("add_op_count", op_count, 16'd1);

    preload(5'd4, 32'd9);
    preload(5'd5, 32'd9);
    old7 = ram[7];
    applyStimulus(4'd1, 5'd4, 5'd5, 5'd7, 1'b0, 0, lat);
    checkOutput("cmp_done_offset", lat, 3);
    checkOutput("cmp_result", result, 32'd0);
    checkOutput("cmp_zf", ZF, 1);
    checkOutput("cmp_ram7", ram[7], old7);

    preload(5'd6, 32'd10);
    applyStimulus(4'd0, 5'd6, 5'd6, 5'd6, 1'b1, 0, lat);
    checkOutput("inplace_1", ram[6], 32'd20);
    applyStimulus(4'd0, 5'd6, 5'd6, 5'd6, 1'b1, 0, lat);
    checkOutput("inplace_2", ram[6], 32'd40);

    preload(5'd8, 32'd100);
    preload(5'd9, 32'd1);
    dc = done_cnt;
    applyStimulus(4'd1, 5'd8, 5'd9, 5'd10, 1'b1, 2, lat);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reject_done_count", done_cnt - dc, 1);
    checkOutput("reject_op_count", op_count, 16'd5);
    checkOutput("reject_ram10", ram[10], 32'd99);

    for (int n = 0; n < 60; n++) begin
      applyStimulus(OP_W'($urandom_range(0, 4)), ADDR_W'($urandom), ADDR_W'($urandom),
                    ADDR_W'($urandom), 1'($urandom), 1, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    abortAt(3, 5'd12);
    abortAt(1, 5'd13);

    @(negedge clk); #1;
    force dut.op_count_q = 16'hFFFE;
    cnt_sync = 1'b1;
    @(posedge clk); #1;
    release dut.op_count_q;
    cnt_sync = 1'b0;
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd14, 1'b1, 0, lat);
    checkOutput("wrap_ffff", op_count, 16'hFFFF);
    applyStimulus(4'd1, 5'd4, 5'd5, 5'd15, 1'b0, 0, lat);
    checkOutput("wrap_zero", op_count, 16'h0000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
